// File: rtl/timer_periph.sv
// Memory-mapped countdown timer: firmware writes a tick count N, the block counts
// prescaled ticks down to zero and raises a sticky done flag readable at 0x201C.
module timer_periph #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int SIM_DIV     = 4,
    parameter bit Simulacion  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        TIMER_ctrl_we,
    input  logic [31:0] TIMER_ctrl_wdata,
    output logic [31:0] TIMER_done_rdata,
    output logic        done_pulse,
    output logic        busy,
    output logic [23:0] remaining
);
    localparam int DIV = Simulacion ? SIM_DIV : CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [PW-1:0] pcnt;
    logic [23:0]   rem;
    logic          done;
    logic [23:0]   wr_n;
    logic          unused_hi;

    assign wr_n      = TIMER_ctrl_wdata[23:0];
    assign unused_hi = ^TIMER_ctrl_wdata[31:24];

    // A write always takes priority over the countdown, including on the expiry edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pcnt       <= '0;
            rem        <= '0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (TIMER_ctrl_we) begin
                pcnt  <= '0;
                done  <= 1'b0;
                rem   <= wr_n;
                state <= (wr_n != 24'd0) ? RUN : IDLE;
            end else begin
                case (state)
                    RUN: begin
                        if (pcnt == DIV_M1) begin
                            pcnt <= '0;
                            rem  <= rem - 24'd1;
                            if (rem == 24'd1) begin
                                state      <= DONE;
                                done       <= 1'b1;
                                done_pulse <= 1'b1;
                            end
                        end else begin
                            pcnt <= pcnt + PW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy             = (state == RUN);
    assign remaining        = rem;
    assign TIMER_done_rdata = {31'b0, done};
endmodule

// File: tb/tb_timer_periph.sv
// Directed bench for timer_periph with SIM_DIV=4: per-cycle vector table plus
// a hand-written asynchronous-reset sequence.
module tb_timer_periph;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        TIMER_ctrl_we = 1'b0;
    logic [31:0] TIMER_ctrl_wdata = '0;
    logic [31:0] TIMER_done_rdata;
    logic        done_pulse;
    logic        busy;
    logic [23:0] remaining;

    int tests = 0;
    int fails = 0;

    timer_periph #(
        .CLK_FREQ_HZ(100_000_000),
        .TICK_HZ    (1000),
        .SIM_DIV    (4),
        .Simulacion (1'b1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .TIMER_ctrl_we   (TIMER_ctrl_we),
        .TIMER_ctrl_wdata(TIMER_ctrl_wdata),
        .TIMER_done_rdata(TIMER_done_rdata),
        .done_pulse      (done_pulse),
        .busy            (busy),
        .remaining       (remaining)
    );

    always #5 clk = ~clk;

    // One record per clock: inputs before the edge, expected outputs after it.
    typedef struct {
        logic        we;
        logic [31:0] wdata;
        logic        done;
        logic        pulse;
        logic        busy;
        logic [23:0] rem;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [31:0] wdata, input logic done,
                       input logic pulse, input logic bsy, input logic [23:0] rem,
                       input int reps);
        vec_t v;
        v.we = we; v.wdata = wdata; v.done = done; v.pulse = pulse; v.busy = bsy; v.rem = rem;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endtask

    task automatic check_outs(input string name, input int idx, input logic done,
                              input logic pulse, input logic bsy, input logic [23:0] rem);
        tests++;
        if (TIMER_done_rdata !== {31'b0, done} || done_pulse !== pulse ||
            busy !== bsy || remaining !== rem) begin
            fails++;
            $display("FAIL %s[%0d]: got rdata=%h pulse=%b busy=%b rem=%0d, want rdata=%h pulse=%b busy=%b rem=%0d",
                     name, idx, TIMER_done_rdata, done_pulse, busy, remaining,
                     {31'b0, done}, pulse, bsy, rem);
        end
    endtask

    initial begin
        bit seen;

        // write 3: rem steps 3,2,1,0 every 4 cycles, done 12 cycles after the write
        add(1, 32'd3, 0, 0, 1, 24'd3, 1);
        add(0, 32'd0, 0, 0, 1, 24'd3, 3);
        add(0, 32'd0, 0, 0, 1, 24'd2, 4);
        add(0, 32'd0, 0, 0, 1, 24'd1, 4);
        add(0, 32'd0, 1, 1, 0, 24'd0, 1);
        add(0, 32'd0, 1, 0, 0, 24'd0, 50);  // sticky, pulse only once
        add(1, 32'd0, 0, 0, 0, 24'd0, 1);   // clear-done
        add(0, 32'd0, 0, 0, 0, 24'd0, 2);
        // write 10 then restart with 2 twenty cycles later
        add(1, 32'd10, 0, 0, 1, 24'd10, 1);
        add(0, 32'd0, 0, 0, 1, 24'd10, 3);
        add(0, 32'd0, 0, 0, 1, 24'd9, 4);
        add(0, 32'd0, 0, 0, 1, 24'd8, 4);
        add(0, 32'd0, 0, 0, 1, 24'd7, 4);
        add(0, 32'd0, 0, 0, 1, 24'd6, 4);
        add(1, 32'd2, 0, 0, 1, 24'd2, 1);
        add(0, 32'd0, 0, 0, 1, 24'd2, 3);
        add(0, 32'd0, 0, 0, 1, 24'd1, 4);
        add(0, 32'd0, 1, 1, 0, 24'd0, 1);
        add(0, 32'd0, 1, 0, 0, 24'd0, 15);  // covers old count's cycle 40
        // restart from DONE with upper byte set: only [23:0] counts
        add(1, 32'hFF00_0002, 0, 0, 1, 24'd2, 1);
        add(0, 32'd0, 0, 0, 1, 24'd2, 3);
        add(0, 32'd0, 0, 0, 1, 24'd1, 4);
        add(0, 32'd0, 1, 1, 0, 24'd0, 1);
        add(0, 32'd0, 1, 0, 0, 24'd0, 2);
        // count of 1, write 3 on its expiry edge: write wins
        add(1, 32'd1, 0, 0, 1, 24'd1, 1);
        add(0, 32'd0, 0, 0, 1, 24'd1, 3);
        add(1, 32'd3, 0, 0, 1, 24'd3, 1);
        add(0, 32'd0, 0, 0, 1, 24'd3, 3);
        add(0, 32'd0, 0, 0, 1, 24'd2, 4);
        add(0, 32'd0, 0, 0, 1, 24'd1, 4);
        add(0, 32'd0, 1, 1, 0, 24'd0, 1);
        add(0, 32'd0, 1, 0, 0, 24'd0, 2);
        // abort mid-run
        add(1, 32'd5, 0, 0, 1, 24'd5, 1);
        add(0, 32'd0, 0, 0, 1, 24'd5, 3);
        add(1, 32'd0, 0, 0, 0, 24'd0, 1);
        add(0, 32'd0, 0, 0, 0, 24'd0, 25);  // nothing expires afterwards

        repeat (3) @(posedge clk);
        #1;
        check_outs("reset_held", 0, 0, 0, 0, 24'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_outs("reset_state", 0, 0, 0, 0, 24'd0);

        foreach (vecs[i]) begin
            TIMER_ctrl_we    = vecs[i].we;
            TIMER_ctrl_wdata = vecs[i].wdata;
            @(posedge clk); #1;
            check_outs("vec", i, vecs[i].done, vecs[i].pulse, vecs[i].busy, vecs[i].rem);
        end
        TIMER_ctrl_we = 1'b0;
        TIMER_ctrl_wdata = '0;

        // write 5, then asynchronous reset mid-clock 7 cycles later
        TIMER_ctrl_we = 1'b1;
        TIMER_ctrl_wdata = 32'd5;
        @(posedge clk); #1;
        TIMER_ctrl_we = 1'b0;
        TIMER_ctrl_wdata = '0;
        repeat (6) @(posedge clk);
        #2;
        check_outs("pre_async_reset", 0, 0, 0, 1, 24'd4);
        #1;
        reset = 1'b1;
        #1;
        check_outs("async_reset", 0, 0, 0, 0, 24'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (TIMER_done_rdata != 32'd0 || done_pulse || busy || remaining != 24'd0) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL post_reset_quiet: got activity=%b, want activity=0", seen);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
